mem_port_arbiter: RTL and testbench

Shares the single memory port of the multi-cycle RV32I core between the instruction-fetch requester and the load/store requester. Each request is latched, driven onto the memory port for a fixed access latency, and answered with a one-cycle response pulse to the requester that was granted. The block sits between the core FSM and the `memory` instance and sequences every memory access; the core never drives the memory directly.

---
 rtl/mem_port_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single memory port of the multi-cycle RV32I core between the
// instruction-fetch requester and the load/store requester. A granted request
// is latched onto the mem_* registers, held for MEM_LATENCY cycles, and
// answered with a one-cycle rvalid pulse to the winning port.
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN  defined   -> ties go to the port opposite last_d
//                           undefined -> ties always go to the data port
//
// Parameters:
//   MEM_LATENCY  cycles from mem_addr presented to mem_rdata valid (1..7)
//
// Ports:
//   clk, reset                 rising-edge clock, async active-low reset
//   if_req/if_addr             fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata  fetch accept pulse, response pulse, data
//   d_req/d_we/d_addr/
//   d_wdata/d_funct3           data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata     data accept pulse, response pulse, data
//   mem_addr/mem_wren/
//   mem_wdata/mem_funct3       registered memory port drive
//   mem_rdata                  memory read data
//   mem_sel_d                  current access belongs to the data port
//   busy                       block is not in IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_funct3,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wren,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata,
    output logic        mem_sel_d,
    output logic        busy
);

    generate
        if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : g_bad_latency
            $error("mem_port_arbiter: MEM_LATENCY must be within 1..7");
        end
    endgenerate

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic        last_d, last_d_n;
    logic        acc_we, acc_we_n;   // current access is a store

    logic        if_gnt_n, if_rvalid_n, d_gnt_n, d_rvalid_n;
    logic [31:0] if_rdata_n, d_rdata_n;
    logic [31:0] mem_addr_n, mem_wdata_n;
    logic        mem_wren_n, mem_sel_d_n, busy_n;
    logic [2:0]  mem_funct3_n;

    logic        tie_d;
    logic        pick_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign tie_d = ~last_d;
`else
    assign tie_d = 1'b1;
`endif

    // Data wins when it is the only requester, or on a tie resolved to data.
    assign pick_d = d_req & (~if_req | tie_d);

    // State and registered-output storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            last_d     <= 1'b1;
            acc_we     <= 1'b0;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= 32'd0;
            d_gnt      <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= 32'd0;
            mem_addr   <= 32'd0;
            mem_wren   <= 1'b0;
            mem_wdata  <= 32'd0;
            mem_funct3 <= 3'd0;
            mem_sel_d  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            last_d     <= last_d_n;
            acc_we     <= acc_we_n;
            if_gnt     <= if_gnt_n;
            if_rvalid  <= if_rvalid_n;
            if_rdata   <= if_rdata_n;
            d_gnt      <= d_gnt_n;
            d_rvalid   <= d_rvalid_n;
            d_rdata    <= d_rdata_n;
            mem_addr   <= mem_addr_n;
            mem_wren   <= mem_wren_n;
            mem_wdata  <= mem_wdata_n;
            mem_funct3 <= mem_funct3_n;
            mem_sel_d  <= mem_sel_d_n;
            busy       <= busy_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (if_req || d_req) state_n = ACCESS;
            ACCESS:  if (cnt == 3'd1)     state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        // Pulses default low; everything else holds.
        if_gnt_n     = 1'b0;
        d_gnt_n      = 1'b0;
        if_rvalid_n  = 1'b0;
        d_rvalid_n   = 1'b0;
        mem_wren_n   = 1'b0;
        if_rdata_n   = if_rdata;
        d_rdata_n    = d_rdata;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        mem_funct3_n = mem_funct3;
        mem_sel_d_n  = mem_sel_d;
        cnt_n        = cnt;
        last_d_n     = last_d;
        acc_we_n     = acc_we;
        busy_n       = (state_n != IDLE);

        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    cnt_n    = LAT;
                    last_d_n = pick_d;
                    if (pick_d) begin
                        mem_addr_n   = d_addr;
                        mem_wren_n   = d_we;
                        mem_wdata_n  = d_wdata;
                        mem_funct3_n = d_funct3;
                        mem_sel_d_n  = 1'b1;
                        acc_we_n     = d_we;
                        d_gnt_n      = 1'b1;
                    end else begin
                        mem_addr_n   = if_addr;
                        mem_wren_n   = 1'b0;
                        mem_wdata_n  = 32'd0;
                        mem_funct3_n = 3'b010;
                        mem_sel_d_n  = 1'b0;
                        acc_we_n     = 1'b0;
                        if_gnt_n     = 1'b1;
                    end
                end
            end
            ACCESS: begin
                cnt_n = cnt - 3'd1;
                // Counter at 1 marks the edge on which mem_rdata is valid.
                if (cnt == 3'd1) begin
                    if (mem_sel_d) begin
                        d_rdata_n  = acc_we ? 32'd0 : mem_rdata;
                        d_rvalid_n = 1'b1;
                    end else begin
                        if_rdata_n  = mem_rdata;
                        if_rvalid_n = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } resp_t;

    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latency-1 instance signals
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [2:0]  d_funct3;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_wren, mem_sel_d, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_funct3;

    // Latency-3 instance signals
    logic        if_req3, d_req3, d_we3;
    logic [31:0] if_addr3, d_addr3, d_wdata3;
    logic [2:0]  d_funct3_3;
    logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_wren3, mem_sel_d3, busy3;
    logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic [2:0]  mem_funct3_3;

    logic [31:0] pcnt = 32'd0;
    always @(posedge clk) pcnt <= pcnt + 32'd1;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h10) ? 32'h13 : (a ^ 32'hDEAD_BEEF);
    endfunction

    assign mem_rdata  = mem_model(mem_addr);
    assign mem_rdata3 = 32'hC0DE_0000 + pcnt;   // changes every cycle

    mem_port_arbiter #(.MEM_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_funct3(d_funct3), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_rdata(mem_rdata), .mem_sel_d(mem_sel_d),
        .busy(busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3),
        .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_funct3(d_funct3_3), .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .mem_addr(mem_addr3), .mem_wren(mem_wren3), .mem_wdata(mem_wdata3),
        .mem_funct3(mem_funct3_3), .mem_rdata(mem_rdata3), .mem_sel_d(mem_sel_d3),
        .busy(busy3)
    );

    int    total = 0;
    int    bad   = 0;
    bit    exp_gnt[$];
    resp_t exp_resp[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_fetch(input logic [31:0] a);
        resp_t r;
        r.is_d = 1'b0;
        r.data = mem_model(a);
        exp_gnt.push_back(1'b0);
        exp_resp.push_back(r);
    endtask

    task automatic push_data(input logic we, input logic [31:0] a);
        resp_t r;
        r.is_d = 1'b1;
        r.data = we ? 32'd0 : mem_model(a);
        exp_gnt.push_back(1'b1);
        exp_resp.push_back(r);
    endtask

    // Scoreboard: grant order and response payloads of the latency-1 instance.
    always @(negedge clk) begin
        if (if_gnt || d_gnt) begin
            chk("gnt_onehot", {31'd0, if_gnt & d_gnt}, 32'd0);
            chk("gnt_expected", {31'd0, exp_gnt.size() != 0}, 32'd1);
            if (exp_gnt.size() != 0) chk("gnt_port", {31'd0, d_gnt}, {31'd0, exp_gnt.pop_front()});
        end
        if (if_rvalid || d_rvalid) begin
            chk("rsp_expected", {31'd0, exp_resp.size() != 0}, 32'd1);
            if (exp_resp.size() != 0) begin
                resp_t r;
                r = exp_resp.pop_front();
                chk("rsp_port", {31'd0, d_rvalid}, {31'd0, r.is_d});
                if (r.is_d) chk("d_rdata", d_rdata, r.data);
                else        chk("if_rdata", if_rdata, r.data);
            end
        end
    end

    task automatic wait_gnt(input bit is_d);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = is_d ? d_gnt : if_gnt;
        end
        if (is_d) chk("d_gnt_wait", {31'd0, seen}, 32'd1);
        else      chk("if_gnt_wait", {31'd0, seen}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || exp_resp.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_resp.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int    grants, guard, lat;
        bit    rv;
        logic [31:0] g, exp3;

        reset = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_funct3 = 0;
        if_req3 = 0; if_addr3 = 0; d_req3 = 0; d_we3 = 0; d_addr3 = 0; d_wdata3 = 0; d_funct3_3 = 0;
        #1;
        chk("rst_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
        chk("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ctl", {27'd0, mem_wren, mem_sel_d, busy, 2'd0}, 32'd0);
        chk("rst_funct3", {29'd0, mem_funct3}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single fetch
        @(negedge clk);
        if_req = 1; if_addr = 32'h10;
        push_fetch(32'h10);
        wait_gnt(0);
        chk("f_mem_addr", mem_addr, 32'h10);
        chk("f_funct3", {29'd0, mem_funct3}, 32'd2);
        chk("f_wren", {31'd0, mem_wren}, 32'd0);
        chk("f_sel_d", {31'd0, mem_sel_d}, 32'd0);
        chk("f_busy", {31'd0, busy}, 32'd1);
        if_req = 0;
        @(negedge clk);
        chk("f_rvalid", {31'd0, if_rvalid}, 32'd1);
        @(negedge clk);
        chk("f_busy_fall", {31'd0, busy}, 32'd0);
        chk("f_rdata_hold", if_rdata, 32'h13);

        // Load (leaves non-zero d_rdata before the store)
        d_req = 1; d_we = 0; d_addr = 32'h100; d_funct3 = 3'b010;
        push_data(0, 32'h100);
        wait_gnt(1);
        d_req = 0;
        drain();

        // Store
        d_req = 1; d_we = 1; d_addr = 32'hFFFF_FFFC; d_wdata = 32'hA5A5_A5A5; d_funct3 = 3'b010;
        push_data(1, 32'hFFFF_FFFC);
        wait_gnt(1);
        chk("s_wren", {31'd0, mem_wren}, 32'd1);
        chk("s_addr", mem_addr, 32'hFFFF_FFFC);
        chk("s_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk("s_funct3", {29'd0, mem_funct3}, 32'd2);
        chk("s_sel_d", {31'd0, mem_sel_d}, 32'd1);
        d_req = 0; d_we = 0;
        @(negedge clk);
        chk("s_wren_fall", {31'd0, mem_wren}, 32'd0);
        chk("s_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("s_sel_hold", {31'd0, mem_sel_d}, 32'd1);
        drain();

        // Tie arbitration from a fresh reset
        do_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push_fetch(32'h40); push_data(0, 32'h200); push_fetch(32'h40); push_data(0, 32'h200);
`else
        push_data(0, 32'h200); push_fetch(32'h40); push_data(0, 32'h200); push_fetch(32'h40);
`endif
        @(negedge clk);
        if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h200;
        grants = 0; guard = 0;
        while (grants < 4 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (if_gnt || d_gnt) grants++;
`ifndef MEM_ARB_ROUND_ROBIN_EN
            if (d_gnt) d_req = 0;
            if (if_gnt) begin
                if_req = 0;
                if (grants == 2) begin if_req = 1; d_req = 1; end
            end
`endif
        end
        if_req = 0; d_req = 0;
        chk("tie_grants", grants, 32'd4);
        drain();

        // Latency-3 load with mem_rdata changing every cycle
        @(negedge clk);
        d_req3 = 1; d_we3 = 0; d_addr3 = 32'h2000; d_funct3_3 = 3'b010;
        guard = 0;
        while (!d_gnt3 && guard < 20) begin @(negedge clk); guard++; end
        chk("l3_gnt", {31'd0, d_gnt3}, 32'd1);
        g = pcnt;
        exp3 = 32'hC0DE_0000 + g + 32'd2;
        chk("l3_addr", mem_addr3, 32'h2000);
        d_req3 = 0;
        lat = 0;
        while (!d_rvalid3 && lat < 20) begin @(negedge clk); lat++; end
        chk("l3_latency", lat, 32'd3);
        chk("l3_rdata", d_rdata3, exp3);
        repeat (2) @(negedge clk);
        chk("l3_rvalid_fall", {31'd0, d_rvalid3}, 32'd0);
        chk("l3_hold", d_rdata3, exp3);
        chk("l3_busy", {31'd0, busy3}, 32'd0);

        // Reset during the first ACCESS cycle of a store
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h1234_5678;
        exp_gnt.push_back(1'b1);
        wait_gnt(1);
        chk("ab_wren", {31'd0, mem_wren}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("ab_wren_async", {31'd0, mem_wren}, 32'd0);
        chk("ab_gnt_async", {31'd0, d_gnt}, 32'd0);
        chk("ab_busy_async", {31'd0, busy}, 32'd0);
        d_req = 0; d_we = 0;
        rv = 1'b0;
        repeat (3) begin @(negedge clk); rv |= d_rvalid; end
        reset = 1'b1;
        repeat (3) begin @(negedge clk); rv |= d_rvalid; end
        chk("ab_no_rvalid", {31'd0, rv}, 32'd0);
        if_req = 1; if_addr = 32'h44;
        push_fetch(32'h44);
        wait_gnt(0);
        chk("ab_f_addr", mem_addr, 32'h44);
        if_req = 0;
        drain();

        chk("sb_left", exp_gnt.size() + exp_resp.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
